// File: rtl/alu_div_sequencer.sv
// Restoring shift-subtract divider for RV64M DIV/DIVU/REM/REMU (+W) that borrows the shared integer ALU.
// Latency 65/68 (64-bit), 33/36 (W), 1 for divide-by-zero/overflow; start ignored while busy, kill aborts.
module alu_div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_alu_s,
  input  logic            i_alu_lu,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [2:0]      o_alu_func,
  output logic            o_alu_sub_sra,
  output logic            o_alu_sel_32b,
  output logic            o_alu_own,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [2:0] {S_IDLE, S_ABS_A, S_ABS_B, S_ITER, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_op;
  logic            r_word;
  logic [5:0]      r_cnt;
  logic [XLEN-1:0] r_p;
  logic [XLEN-1:0] r_d;
  logic [XLEN-1:0] r_b;
  logic            r_negq;
  logic            r_negr;

  logic            w_signed;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic [XLEN-1:0] w_a_load;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_p_iter;
  logic [XLEN-1:0] w_d_iter;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_res_ext;

  assign o_alu_func    = 3'b000;
  assign o_alu_sel_32b = 1'b0;

  always_comb begin
    w_signed   = ~i_op[0];
    w_a_ext    = i_rs1;
    w_b_ext    = i_rs2;
    if (i_word) begin
      w_a_ext = {{32{w_signed & i_rs1[31]}}, i_rs1[31:0]};
      w_b_ext = {{32{w_signed & i_rs2[31]}}, i_rs2[31:0]};
    end
    // W dividends sit in the top half so the iteration always consumes D[msb].
    w_a_load   = i_word ? {w_a_ext[31:0], 32'b0} : w_a_ext;
    w_div_zero = (w_b_ext == '0);
    w_ovf      = w_signed && (&w_b_ext) &&
                 (i_word ? (w_a_ext == {32'hFFFF_FFFF, 32'h8000_0000})
                         : (w_a_ext == {1'b1, 63'b0}));
    w_abs_a    = r_d[63] ? i_alu_s : r_d;
    w_abs_b    = r_b[63] ? i_alu_s : r_b;
    // o_alu_a holds the shifted partial remainder P' during ITER.
    w_p_iter   = i_alu_lu ? o_alu_a : i_alu_s;
    w_d_iter   = {r_d[62:0], ~i_alu_lu};
    w_sel      = r_op[1] ? r_p : r_d;
    w_res_ext  = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_op          <= 2'b00;
      r_word        <= 1'b0;
      r_cnt         <= 6'd0;
      r_p           <= '0;
      r_d           <= '0;
      r_b           <= '0;
      r_negq        <= 1'b0;
      r_negr        <= 1'b0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_sub_sra <= 1'b0;
      o_alu_own     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= '0;
    end else if (i_kill && r_state != S_IDLE) begin
      r_state       <= S_IDLE;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_sub_sra <= 1'b0;
      o_alu_own     <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_kill) begin
            r_op   <= i_op;
            r_word <= i_word;
            r_b    <= w_b_ext;
            r_cnt  <= i_word ? 6'd31 : 6'd63;
            r_p    <= '0;
            o_busy <= 1'b1;
            if (w_div_zero) begin
              r_d     <= '1;
              r_p     <= w_a_ext;
              r_state <= S_DONE;
            end else if (w_ovf) begin
              r_d     <= w_a_ext;
              r_state <= S_DONE;
            end else if (w_signed) begin
              r_d           <= w_a_ext;
              o_alu_a       <= '0;
              o_alu_b       <= w_a_ext;
              o_alu_sub_sra <= 1'b1;
              o_alu_own     <= 1'b1;
              r_state       <= S_ABS_A;
            end else begin
              r_d           <= w_a_load;
              o_alu_a       <= {63'b0, w_a_load[63]};
              o_alu_b       <= w_b_ext;
              o_alu_sub_sra <= 1'b1;
              o_alu_own     <= 1'b1;
              r_state       <= S_ITER;
            end
          end
        end
        S_ABS_A: begin
          r_d     <= r_word ? {w_abs_a[31:0], 32'b0} : w_abs_a;
          r_negq  <= r_d[63] ^ r_b[63];
          r_negr  <= r_d[63];
          o_alu_b <= r_b;
          r_state <= S_ABS_B;
        end
        S_ABS_B: begin
          r_b     <= w_abs_b;
          o_alu_a <= {63'b0, r_d[63]};
          o_alu_b <= w_abs_b;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_p   <= w_p_iter;
          r_d   <= w_d_iter;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt != 6'd0) begin
            o_alu_a <= {w_p_iter[62:0], w_d_iter[63]};
          end else if (!r_op[0]) begin
            o_alu_a <= '0;
            o_alu_b <= r_op[1] ? w_p_iter : w_d_iter;
            r_state <= S_FIX;
          end else begin
            o_alu_a       <= '0;
            o_alu_b       <= '0;
            o_alu_sub_sra <= 1'b0;
            o_alu_own     <= 1'b0;
            r_state       <= S_DONE;
          end
        end
        S_FIX: begin
          // The ALU computes 0 - selected result; it is kept only when the recorded sign asks for it.
          if (r_op[1] && r_negr) r_p <= i_alu_s;
          if (!r_op[1] && r_negq) r_d <= i_alu_s;
          o_alu_b       <= '0;
          o_alu_sub_sra <= 1'b0;
          o_alu_own     <= 1'b0;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          o_result <= w_res_ext;
          o_done   <= 1'b1;
          o_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: models the shared ALU and checks results/latency against an arithmetic reference.
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, kill, word;
  logic [1:0]  op;
  logic [63:0] rs1, rs2, alu_s;
  logic        alu_lu;
  logic [63:0] alu_a, alu_b, result;
  logic [2:0]  alu_func;
  logic        alu_sub_sra, alu_sel_32b, alu_own, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign alu_s  = alu_sub_sra ? alu_a - alu_b : alu_a + alu_b;
  assign alu_lu = (alu_a < alu_b);

  alu_div_sequencer #(.XLEN(64)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_kill(kill),
    .i_op(op), .i_word(word), .i_rs1(rs1), .i_rs2(rs2),
    .i_alu_s(alu_s), .i_alu_lu(alu_lu),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_func(alu_func),
    .o_alu_sub_sra(alu_sub_sra), .o_alu_sel_32b(alu_sel_32b),
    .o_alu_own(alu_own), .o_busy(busy), .o_done(done), .o_result(result)
  );

  function automatic logic [63:0] ext_op(input logic [63:0] v, input logic w, input logic sgn);
    if (!w) return v;
    return sgn ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic w,
                                             input logic [63:0] x, input logic [63:0] y);
    logic        sgn;
    logic [63:0] a, b, q, r, v;
    sgn = !o[0];
    a = ext_op(x, w, sgn);
    b = ext_op(y, w, sgn);
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = 64'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    v = o[1] ? r : q;
    if (w) v = {{32{v[31]}}, v[31:0]};
    return v;
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic w,
                                     input logic [63:0] x, input logic [63:0] y);
    logic        sgn;
    logic [63:0] a, b;
    sgn = !o[0];
    a = ext_op(x, w, sgn);
    b = ext_op(y, w, sgn);
    if (b == 64'd0) return 1;
    if (sgn && b == '1 && a == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
    return (w ? 32 : 64) + (sgn ? 3 : 0) + 1;
  endfunction

  // Issues one operation and waits (bounded) for done; lat=0 means it never came.
  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output bit own_seen, output bit ctrl_bad);
    op = o; word = w; rs1 = a; rs2 = b; start = 1'b1;
    own_seen = 0; ctrl_bad = 0; lat = 0; res = '0;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (alu_own) own_seen = 1;
      if (!alu_own && (alu_a != 0 || alu_b != 0 || alu_sub_sra)) ctrl_bad = 1;
      if (alu_func != 3'b000 || alu_sel_32b) ctrl_bad = 1;
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [201:0] outs;
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; word = 1'b0; rs1 = '0; rs2 = '0;
    #3;
    outs = {busy, done, alu_own, alu_sub_sra, alu_sel_32b, alu_func, alu_a, alu_b, result};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", outs); end
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 2'b01; rs1 = 64'd9; rs2 = 64'd3;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_holds_idle: busy got %b exp 0", busy); end
    start = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op  [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
    logic        t_w   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] t_a   [10] = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                                64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h1234_5678_8000_0000,
                                64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_FFFF_FFF9};
    logic [63:0] t_b   [10] = '{64'd7, 64'd7, 64'd2, 64'd2, 64'd0, 64'd0, '1, '1, 64'd2, 64'd2};
    logic [63:0] t_exp [10] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'd5,
                                64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                                64'h0000_0000_7FFF_FFFF, '1};
    int          t_lat [10] = '{65, 65, 68, 68, 1, 1, 1, 1, 33, 36};
    logic [63:0] res;
    int          lat;
    bit          own_seen, ctrl_bad;
    for (int i = 0; i < 10; i++) begin
      run_op(t_op[i], t_w[i], t_a[i], t_b[i], res, lat, own_seen, ctrl_bad);
      checks++;
      if (res !== t_exp[i]) begin errors++; $display("FAIL directed_result[%0d]: got %h exp %h", i, res, t_exp[i]); end
      checks++;
      if (lat != t_lat[i]) begin errors++; $display("FAIL directed_latency[%0d]: got %0d exp %0d", i, lat, t_lat[i]); end
      checks++;
      if (ctrl_bad) begin errors++; $display("FAIL directed_alu_ctrl[%0d]: got bad exp clean", i); end
      if (t_lat[i] == 1) begin
        checks++;
        if (own_seen) begin errors++; $display("FAIL directed_fast_own[%0d]: got 1 exp 0", i); end
      end
    end
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 1000));
      2: return 64'd0;
      3: return '1;
      4: return $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      default: return {{32{1'b0}}, $urandom};
    endcase
  endfunction

  task automatic test_random;
    logic [1:0]  o;
    logic        w;
    logic [63:0] a, b, res, exp_res;
    int          lat, exp_lat;
    bit          own_seen, ctrl_bad;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      w = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      if ($urandom_range(0, 3) == 0) b = '1;
      exp_res = ref_result(o, w, a, b);
      exp_lat = ref_latency(o, w, a, b);
      run_op(o, w, a, b, res, lat, own_seen, ctrl_bad);
      checks++;
      if (res !== exp_res) begin
        errors++;
        $display("FAIL random_result op=%0d w=%0d a=%h b=%h: got %h exp %h", o, w, a, b, res, exp_res);
      end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL random_latency op=%0d w=%0d: got %0d exp %0d", o, w, lat, exp_lat); end
      checks++;
      if (ctrl_bad || (exp_lat == 1 && own_seen)) begin
        errors++; $display("FAIL random_alu_ctrl op=%0d w=%0d: own_seen=%0d bad=%0d", o, w, own_seen, ctrl_bad);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res;
    int          lat;
    bit          own_seen, ctrl_bad;
    run_op(2'd1, 1'b0, 64'd1000, 64'd10, res, lat, own_seen, ctrl_bad);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_on_done: got %b exp 0", busy); end
    run_op(2'd2, 1'b1, 64'd50, 64'hFFFF_FFFF_FFFF_FFF9, res, lat, own_seen, ctrl_bad);
    checks++;
    if (res !== 64'd1 || lat != 36) begin errors++; $display("FAIL b2b_second: got %h/%0d exp 1/36", res, lat); end
  endtask

  task automatic test_start_ignored;
    int lat = 0;
    op = 2'd1; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 2'd2; rs1 = 64'd9; rs2 = 64'd3;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 7; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    checks++;
    if (result !== 64'd14 || lat != 65) begin errors++; $display("FAIL start_while_busy: got %h/%0d exp 14/65", result, lat); end
  endtask

  task automatic test_kill;
    bit saw_done = 0;
    op = 2'd3; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    checks++;
    if ({busy, alu_own, done} !== 3'b000) begin errors++; $display("FAIL kill_state: got busy/own/done %b exp 000", {busy, alu_own, done}); end
    checks++;
    if (result !== 64'd14) begin errors++; $display("FAIL kill_result_hold: got %h exp 14", result); end
    repeat (80) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL kill_no_done: got done exp none"); end
    start = 1'b1; kill = 1'b1;
    @(posedge clk); #1 start = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_idle: busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [201:0] outs;
    logic [63:0]  res;
    int           lat;
    bit           own_seen, ctrl_bad;
    op = 2'd1; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    outs = {busy, done, alu_own, alu_sub_sra, alu_sel_32b, alu_func, alu_a, alu_b, result};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_mid_outputs: got %h exp 0", outs); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_op(2'd0, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6, res, lat, own_seen, ctrl_bad);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FF9C || lat != 68) begin
      errors++; $display("FAIL reset_mid_recover: got %h/%0d exp ffffffffffffff9c/68", res, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
